// File: rtl/dnn2ami_rd_path.sv
// Breaks DNNWeaver macro read requests into 8-byte AMI reads and routes the
// in-order read data back to the input buffer of the PU that asked for it.
module dnn2ami_rd_path #(
   parameter int NUM_PU                = 2,
   parameter int AXI_ADDR_WIDTH        = 32,
   parameter int AXI_DATA_WIDTH        = 64,
   parameter int TX_SIZE_WIDTH         = 10,
   parameter int NUM_PU_W              = $clog2(NUM_PU) + 1,
   parameter int MACRO_Q_LOG_DEPTH     = 3,
   parameter int TAG_LOG_DEPTH         = 4,
   parameter int AMI_ADDR_WIDTH        = 64,
   parameter int AMI_SIZE_WIDTH        = 64,
   parameter int AMI_REQUEST_BUS_WIDTH = 2 + AMI_ADDR_WIDTH + AXI_DATA_WIDTH + AMI_SIZE_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             rd_req,
   input  logic [NUM_PU_W-1:0]              rd_pu_id,
   input  logic [TX_SIZE_WIDTH-1:0]         rd_req_size,
   input  logic [AXI_ADDR_WIDTH-1:0]        rd_addr,
   output logic                             rd_ready,
   output logic                             rd_done,
   output logic                             reqValid,
   input  logic                             reqOut_grant,
   output logic [AMI_REQUEST_BUS_WIDTH-1:0] reqOut,
   input  logic                             respValid,
   input  logic [AXI_DATA_WIDTH-1:0]        respData,
   output logic                             resp_pop,
   input  logic [NUM_PU-1:0]                inbuf_full,
   output logic [NUM_PU-1:0]                inbuf_push,
   output logic [NUM_PU*AXI_DATA_WIDTH-1:0] data_to_inbuf,
   output logic                             err
);

   localparam int MQ_DEPTH = 1 << MACRO_Q_LOG_DEPTH;
   localparam int MQ_CW    = MACRO_Q_LOG_DEPTH + 1;
   localparam int MQ_W     = AXI_ADDR_WIDTH + TX_SIZE_WIDTH + NUM_PU_W;
   localparam int TQ_DEPTH = 1 << TAG_LOG_DEPTH;
   localparam int TQ_CW    = TAG_LOG_DEPTH + 1;
   localparam int TAG_W    = NUM_PU_W + 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                       state, state_nxt;
   logic                         live;

   logic [MQ_W-1:0]              mq_mem [MQ_DEPTH];
   logic [MACRO_Q_LOG_DEPTH-1:0] mq_wr, mq_rd;
   logic [MQ_CW-1:0]             mq_cnt;
   logic                         mq_full, mq_empty, mq_enq, mq_deq;
   logic [AXI_ADDR_WIDTH-1:0]    mq_addr;
   logic [TX_SIZE_WIDTH-1:0]     mq_size;
   logic [NUM_PU_W-1:0]          mq_pu;

   logic [TAG_W-1:0]             tq_mem [TQ_DEPTH];
   logic [TAG_LOG_DEPTH-1:0]     tq_wr, tq_rd;
   logic [TQ_CW-1:0]             tq_cnt;
   logic                         tq_full, tq_empty, tq_push, tq_pop;
   logic [NUM_PU_W-1:0]          tq_pu;
   logic                         tq_last;

   logic [AXI_ADDR_WIDTH-1:0]    cur_addr;
   logic [TX_SIZE_WIDTH-1:0]     words_left;
   logic [NUM_PU_W-1:0]          cur_pu;
   logic                         zero_done, head_full;
   logic [2:0]                   done_pend, done_sum;

   // Holds outputs quiet through reset and the first cycle after release.
   always_ff @(posedge clk) begin
      if (rst) live <= 1'b0;
      else     live <= 1'b1;
   end

   assign mq_full  = (mq_cnt == MQ_CW'(MQ_DEPTH));
   assign mq_empty = (mq_cnt == '0);
   assign rd_ready = live && !mq_full;
   assign mq_enq   = rd_req && rd_ready;
   assign {mq_addr, mq_size, mq_pu} = mq_mem[mq_rd];

   always_ff @(posedge clk) begin
      if (mq_enq) mq_mem[mq_wr] <= {rd_addr, rd_req_size, rd_pu_id};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mq_wr  <= '0;
         mq_rd  <= '0;
         mq_cnt <= '0;
      end else begin
         if (mq_enq) mq_wr <= mq_wr + MACRO_Q_LOG_DEPTH'(1);
         if (mq_deq) mq_rd <= mq_rd + MACRO_Q_LOG_DEPTH'(1);
         case ({mq_enq, mq_deq})
            2'b10:   mq_cnt <= mq_cnt + MQ_CW'(1);
            2'b01:   mq_cnt <= mq_cnt - MQ_CW'(1);
            default: mq_cnt <= mq_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mq_deq    = 1'b0;
      zero_done = 1'b0;
      reqValid  = 1'b0;
      case (state)
         IDLE: begin
            if (!mq_empty) begin
               mq_deq = 1'b1;
               if (mq_size == '0) zero_done = 1'b1;
               else               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            reqValid = !tq_full;
            if (reqValid && reqOut_grant && words_left == TX_SIZE_WIDTH'(1))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign tq_push = reqValid && reqOut_grant;

   // Fracturing datapath: address walks in 8-byte steps and wraps naturally.
   always_ff @(posedge clk) begin
      if (mq_deq) begin
         cur_addr   <= mq_addr;
         words_left <= mq_size;
         cur_pu     <= mq_pu;
      end else if (tq_push) begin
         cur_addr   <= cur_addr + AXI_ADDR_WIDTH'(8);
         words_left <= words_left - TX_SIZE_WIDTH'(1);
      end
   end

   assign reqOut = {reqValid, 1'b0, AMI_ADDR_WIDTH'(cur_addr),
                    {AXI_DATA_WIDTH{1'b0}}, AMI_SIZE_WIDTH'(8)};

   assign tq_full  = (tq_cnt == TQ_CW'(TQ_DEPTH));
   assign tq_empty = (tq_cnt == '0);
   assign {tq_pu, tq_last} = tq_mem[tq_rd];

   always_ff @(posedge clk) begin
      if (tq_push) tq_mem[tq_wr] <= {cur_pu, words_left == TX_SIZE_WIDTH'(1)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tq_wr  <= '0;
         tq_rd  <= '0;
         tq_cnt <= '0;
      end else begin
         if (tq_push) tq_wr <= tq_wr + TAG_LOG_DEPTH'(1);
         if (tq_pop)  tq_rd <= tq_rd + TAG_LOG_DEPTH'(1);
         case ({tq_push, tq_pop})
            2'b10:   tq_cnt <= tq_cnt + TQ_CW'(1);
            2'b01:   tq_cnt <= tq_cnt - TQ_CW'(1);
            default: tq_cnt <= tq_cnt;
         endcase
      end
   end

   // Response steering: an id with no matching buffer never stalls.
   always_comb begin
      head_full = 1'b0;
      for (int i = 0; i < NUM_PU; i++)
         if (tq_pu == NUM_PU_W'(i)) head_full = inbuf_full[i];
   end

   assign resp_pop      = live && respValid && (tq_empty || !head_full);
   assign tq_pop        = resp_pop && !tq_empty;
   assign data_to_inbuf = {NUM_PU{respData}};

   always_comb begin
      inbuf_push = '0;
      for (int i = 0; i < NUM_PU; i++)
         if (tq_pop && tq_pu == NUM_PU_W'(i)) inbuf_push[i] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)                                 err <= 1'b0;
      else if (live && respValid && tq_empty)  err <= 1'b1;
   end

   // Completion events can coincide; the pending count keeps one pulse per macro.
   assign done_sum = done_pend + {2'b00, tq_pop && tq_last} + {2'b00, zero_done};

   always_ff @(posedge clk) begin
      if (rst) begin
         done_pend <= '0;
         rd_done   <= 1'b0;
      end else begin
         rd_done   <= (done_sum != '0);
         done_pend <= done_sum - {2'b00, done_sum != '0};
      end
   end

endmodule

// File: tb/tb_dnn2ami_rd_path.sv
// Scoreboard bench for dnn2ami_rd_path: a stimulus process issues macros, a
// responder plays the AMI port, and a monitor checks against a queue model.
module tb_dnn2ami_rd_path;

   localparam int NP   = 2;
   localparam int PW   = 2;
   localparam int RW   = 2 + 64 + 64 + 64;
   localparam int TAGS = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            rd_req;
   logic [PW-1:0]   rd_pu_id;
   logic [9:0]      rd_req_size;
   logic [31:0]     rd_addr;
   logic            rd_ready, rd_done, reqValid, reqOut_grant;
   logic [RW-1:0]   reqOut;
   logic            respValid;
   logic [63:0]     respData;
   logic            resp_pop;
   logic [NP-1:0]   inbuf_full, inbuf_push;
   logic [NP*64-1:0] data_to_inbuf;
   logic            err;

   dnn2ami_rd_path dut (
      .clk(clk), .rst(rst), .rd_req(rd_req), .rd_pu_id(rd_pu_id),
      .rd_req_size(rd_req_size), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rd_done(rd_done), .reqValid(reqValid), .reqOut_grant(reqOut_grant),
      .reqOut(reqOut), .respValid(respValid), .respData(respData),
      .resp_pop(resp_pop), .inbuf_full(inbuf_full), .inbuf_push(inbuf_push),
      .data_to_inbuf(data_to_inbuf), .err(err)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0, n_fail = 0;
   logic [31:0] exp_addr[$];
   int          route_pu[$];
   bit          route_last[$];
   logic [63:0] rsp_q[$];
   int          out_n = 0;
   bit          d1 = 0, d2 = 0, err_exp = 0;
   bit          acc = 0, popped = 0;
   int          gnt_mode = 1;
   bit          rsp_en = 1, rsp_rand = 0, rand_full = 0, inject = 0;
   logic [NP-1:0] full_force = '0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
      end
   endtask

   // AMI responder: grants, read data and buffer backpressure.
   initial begin
      respValid = 1'b0; respData = '0; reqOut_grant = 1'b0; inbuf_full = '0;
      forever begin
         @(posedge clk); #1;
         case (gnt_mode)
            0:       reqOut_grant = 1'b0;
            1:       reqOut_grant = 1'b1;
            default: reqOut_grant = 1'($urandom_range(0, 1));
         endcase
         inbuf_full = full_force | (rand_full ? NP'($urandom) : NP'(0));
         if (inject) begin
            respValid = 1'b1;
            respData  = 64'hDEAD_BEEF_0BAD_F00D;
         end else if (respValid && !popped && rsp_q.size() > 0) begin
            respData = rsp_q[0];
         end else if (rsp_en && rsp_q.size() > 0 && (!rsp_rand || $urandom_range(0, 2) != 0)) begin
            respValid = 1'b1;
            respData  = rsp_q[0];
         end else begin
            respValid = 1'b0;
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit            exp_pop, lastpop;
      logic [NP-1:0] exp_push;
      logic [RW-1:0] exp_bus;
      logic [31:0]   a;
      forever begin
         @(negedge clk);
         if (rst) continue;
         lastpop = 0;
         popped  = 0;
         if (out_n == TAGS) chk("tag_limit_reqValid", 256'(reqValid), 256'(0));
         if (respValid) begin
            exp_pop  = (out_n == 0) || !inbuf_full[route_pu[0]];
            exp_push = '0;
            if (out_n > 0 && exp_pop) exp_push[route_pu[0]] = 1'b1;
            chk("resp_pop", 256'(resp_pop), 256'(exp_pop));
            chk("inbuf_push", 256'(inbuf_push), 256'(exp_push));
            if (out_n == 0) begin
               err_exp = 1;
            end else if (exp_pop) begin
               chk("inbuf_data", 256'(data_to_inbuf[route_pu[0]*64 +: 64]), 256'(rsp_q[0]));
               lastpop = route_last[0];
               void'(route_pu.pop_front());
               void'(route_last.pop_front());
               void'(rsp_q.pop_front());
               out_n--;
            end
            popped = exp_pop;
         end else if (resp_pop || inbuf_push != '0) begin
            chk("idle_resp", 256'({resp_pop, inbuf_push}), 256'(0));
         end
         if (reqValid && reqOut_grant) begin
            if (exp_addr.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL req_unexpected: got request %0h, wanted none", reqOut);
            end else begin
               a = exp_addr.pop_front();
               exp_bus = {1'b1, 1'b0, 32'd0, a, 64'd0, 64'd8};
               chk("req_bus", 256'(reqOut), 256'(exp_bus));
               rsp_q.push_back({$urandom, $urandom});
               out_n++;
            end
         end
         if (rd_done || d1) chk("rd_done", 256'(rd_done), 256'(d1));
         d1 = d2 | lastpop;
         d2 = 0;
         if (rd_req && rd_ready && !acc) begin
            acc = 1;
            if (rd_req_size == 0) d2 = 1;
            for (int i = 0; i < int'(rd_req_size); i++) begin
               exp_addr.push_back(rd_addr + 32'(8 * i));
               route_pu.push_back(int'(rd_pu_id));
               route_last.push_back(i == int'(rd_req_size) - 1);
            end
         end
      end
   end

   task automatic send(input int pu, input logic [31:0] addr, input int size);
      @(posedge clk); #1;
      rd_pu_id = PW'(pu); rd_addr = addr; rd_req_size = 10'(size);
      acc = 0; rd_req = 1'b1;
      for (int k = 0; k < 500 && !acc; k++) begin
         @(posedge clk); #1;
      end
      rd_req = 1'b0;
      if (!acc) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: got no accept, wanted rd_ready");
      end
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 3000; k++) begin
         @(posedge clk);
         if (exp_addr.size() == 0 && route_pu.size() == 0 && out_n == 0 && !d1 && !d2) break;
      end
      chk("drain", 256'(route_pu.size()), 256'(0));
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got no finish, wanted completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; rd_req = 1'b0; rd_pu_id = '0; rd_req_size = '0; rd_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_ready", 256'(rd_ready), 256'(0));
      chk("rst_outputs", 256'({reqValid, rd_done, err, resp_pop, inbuf_push}), 256'(0));
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("rel_rd_ready0", 256'(rd_ready), 256'(0));
      @(negedge clk);
      chk("rel_rd_ready1", 256'(rd_ready), 256'(1));

      send(1, 32'h1000, 4);
      wait_idle();

      send(0, 32'h2000, 0);
      repeat (4) begin
         @(negedge clk);
         chk("zero_no_req", 256'(reqValid), 256'(0));
      end
      wait_idle();

      rsp_en = 0; gnt_mode = 0;
      send(0, 32'h4000, 20);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("hold_reqValid", 256'(reqValid), 256'(1));
      @(posedge clk); #1; gnt_mode = 1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("outstanding", 256'(out_n), 256'(TAGS));
      chk("limit_reqValid", 256'(reqValid), 256'(0));
      @(posedge clk); #1; rsp_en = 1;
      wait_idle();

      full_force = 2'b01;
      send(0, 32'h8000, 8);
      repeat (10) @(posedge clk);
      #1; full_force = 2'b00;
      wait_idle();

      gnt_mode = 0;
      send(0, 32'h100, 2);
      send(1, 32'h200, 3);
      @(posedge clk); #1; gnt_mode = 1;
      wait_idle();
      send(0, 32'hFFFF_FFF8, 2);
      wait_idle();

      gnt_mode = 2; rsp_rand = 1; rand_full = 1;
      for (int m = 0; m < 25; m++)
         send($urandom_range(0, 1), $urandom & 32'hFFFF_FFF8, $urandom_range(1, 6));
      wait_idle();
      gnt_mode = 1; rsp_rand = 0; rand_full = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("err_clear", 256'(err), 256'(err_exp));

      @(posedge clk); #3; inject = 1;
      @(posedge clk); #3; inject = 0;
      repeat (2) @(negedge clk);
      chk("err_sticky", 256'(err), 256'(err_exp));
      repeat (3) @(negedge clk);
      chk("err_hold", 256'(err), 256'(1));

      @(posedge clk); #1; rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst2_err", 256'(err), 256'(0));
      chk("rst2_rd_ready", 256'(rd_ready), 256'(0));
      err_exp = 0;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rel2_rd_ready", 256'(rd_ready), 256'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
